sha256_msg_schedule: RTL

SHA256_MSG_SCHEDULE -- requirements
Module: sha256_msg_schedule

---
 rtl/sha_pkg.sv | 22 ++
 rtl/sha_sigma.sv | 12 +
 rtl/sha256_msg_schedule.sv | 86 ++++++++
 3 files changed

// File: rtl/sha_pkg.sv
// Shared SHA-256 definitions: word width, schedule FSM states and the small-sigma
// functions, used by both the message schedule and the compression core.
package sha_pkg;
  localparam int WORD_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] s0(input logic [WORD_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] s1(input logic [WORD_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
endpackage

// File: rtl/sha_sigma.sv
// Combinational small-sigma pair feeding the schedule recurrence.
module sha_sigma
  import sha_pkg::*;
(
  input  logic [WORD_W-1:0] x0,
  input  logic [WORD_W-1:0] x1,
  output logic [WORD_W-1:0] sig0,
  output logic [WORD_W-1:0] sig1
);
  assign sig0 = s0(x0);
  assign sig1 = s1(x1);
endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: accepts a 512-bit block and streams W[0..ROUNDS-1]
// over a valid/ready port from a 16-word sliding window.
module sha256_msg_schedule
  import sha_pkg::*;
#(
  parameter int ROUNDS = 64,
  parameter int WORD_W = 32
)(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              msg_valid,
  output logic              msg_ready,
  input  logic [511:0]      msg,
  input  logic              abort,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [WORD_W-1:0] w_data,
  output logic [5:0]        w_idx,
  output logic              w_last,
  output logic              done
);
  if (WORD_W != 32) begin : g_bad_word_w
    $error("sha256_msg_schedule: WORD_W must be 32");
  end
  if (ROUNDS < 16 || ROUNDS > 64) begin : g_bad_rounds
    $error("sha256_msg_schedule: ROUNDS must be in 16..64");
  end

  state_e                   state, state_nxt;
  logic [15:0][WORD_W-1:0]  win;
  logic [5:0]               t;
  logic [WORD_W-1:0]        sig0, sig1;
  logic                     at_last, xfer;

  assign at_last = (state == RUN) && (t == 6'(ROUNDS - 1));
  // abort wins over w_ready: the handshake is ignored in an aborting cycle
  assign xfer    = (state == RUN) && w_ready && !abort;

  sha_sigma u_sigma (
    .x0   (win[1]),
    .x1   (win[14]),
    .sig0 (sig0),
    .sig1 (sig1)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (msg_valid) state_nxt = RUN;
      RUN:     if (abort || (xfer && at_last)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    msg_ready = (state == IDLE);
    w_valid   = (state == RUN);
    w_last    = at_last;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      win  <= '0;
      t    <= '0;
      done <= 1'b0;
    end else begin
      done <= xfer && at_last;
      if (state == IDLE && msg_valid) begin
        for (int j = 0; j < 16; j++) win[j] <= msg[511-32*j -: 32];
        t <= '0;
      end else if (xfer) begin
        win[14:0] <= win[15:1];
        win[15]   <= win[0] + sig0 + win[9] + sig1;
        t         <= t + 6'd1;
      end
    end
  end

  assign w_data = win[0];
  assign w_idx  = t;
endmodule
